// File: rtl/fetch_pkg.sv
// Shared types and opcode helpers for the instruction-fetch stage and decode.
package fetch_pkg;

    localparam int unsigned OPC_W = 5;

    typedef enum logic [1:0] {
        S_RVEC = 2'd0,
        S_OP   = 2'd1,
        S_IMM  = 2'd2,
        S_IVEC = 2'd3
    } fetch_state_t;

    localparam logic [OPC_W-1:0] OP_NOP  = 5'b00000;
    localparam logic [OPC_W-1:0] OP_LDM  = 5'b11010;
    localparam logic [OPC_W-1:0] OP_IADD = 5'b11011;

    // Opcodes followed by a 16-bit immediate word.
    function automatic logic is_two_word(input logic [OPC_W-1:0] opcode);
        return (opcode == OP_LDM) || (opcode == OP_IADD);
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory port, pipeline control inputs and IF/ID record of the fetch stage.
interface fetch_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 16
);
    logic [ADDR_W-1:0] im_address;
    logic              im_read;
    logic              im_cs;
    logic [INST_W-1:0] im_readData;

    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              int_req;
    logic              int_ack;

    logic              if_valid;
    logic [INST_W-1:0] if_inst;
    logic [INST_W-1:0] if_imm;
    logic [ADDR_W-1:0] if_pc;
    logic [ADDR_W-1:0] if_pc_next;
    logic              if_int;

    modport master (
        output im_address, im_read, im_cs,
        input  im_readData,
        input  stall, redirect, redirect_pc, int_req,
        output int_ack,
        output if_valid, if_inst, if_imm, if_pc, if_pc_next, if_int
    );

    modport slave (
        input  im_address, im_read, im_cs,
        output im_readData,
        output stall, redirect, redirect_pc, int_req,
        input  int_ack,
        input  if_valid, if_inst, if_imm, if_pc, if_pc_next, if_int
    );
endinterface

// File: rtl/pc_reg.sv
// Program counter: load has priority over increment, otherwise hold.
module pc_reg #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    // PC update; increment wraps modulo 2^ADDR_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, reset/interrupt vectors, redirect, stall,
// and assembly of one- and two-word instructions into the IF/ID record.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INST_W  = 16,
    parameter logic [31:0] RST_VEC = 32'd0,
    parameter logic [31:0] INT_VEC = 32'd1
) (
    input logic     clk,
    input logic     rst_n,
    fetch_if.master bus
);

    fetch_state_t      state_q, state_d;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus1;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_val;
    logic              pc_inc;

    logic [INST_W-1:0] word;
    logic [INST_W-1:0] held_inst_q, held_inst_d;
    logic [ADDR_W-1:0] held_pc_q, held_pc_d;

    logic              valid_q, valid_d;
    logic              int_q, int_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [INST_W-1:0] imm_q, imm_d;
    logic [ADDR_W-1:0] rpc_q, rpc_d;
    logic [ADDR_W-1:0] rpcn_q, rpcn_d;
    logic              ack_q, ack_d;

    assign word     = bus.im_readData;
    assign pc_plus1 = pc + ADDR_W'(1);

    pc_reg #(.ADDR_W(ADDR_W)) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_load),
        .load_val (pc_load_val),
        .inc      (pc_inc),
        .pc       (pc)
    );

    // Memory address: vector words in the vector states, PC otherwise.
    always_comb begin
        bus.im_address = pc;
        case (state_q)
            S_RVEC:  bus.im_address = ADDR_W'(RST_VEC);
            S_IVEC:  bus.im_address = ADDR_W'(INT_VEC);
            default: bus.im_address = pc;
        endcase
    end

    assign bus.im_read = rst_n;
    assign bus.im_cs   = rst_n;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RVEC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, PC control, held opcode and next IF/ID record.
    always_comb begin
        state_d     = state_q;
        pc_load     = 1'b0;
        pc_load_val = '0;
        pc_inc      = 1'b0;
        held_inst_d = held_inst_q;
        held_pc_d   = held_pc_q;
        valid_d     = valid_q;
        int_d       = int_q;
        inst_d      = inst_q;
        imm_d       = imm_q;
        rpc_d       = rpc_q;
        rpcn_d      = rpcn_q;
        ack_d       = 1'b0;

        if (bus.redirect && (state_q != S_RVEC)) begin
            // Redirect overrides stall and squashes any half-fetched instruction.
            state_d     = S_OP;
            pc_load     = 1'b1;
            pc_load_val = bus.redirect_pc;
            held_inst_d = '0;
            held_pc_d   = '0;
            valid_d     = 1'b0;
            int_d       = 1'b0;
        end else if (!bus.stall) begin
            case (state_q)
                S_RVEC, S_IVEC: begin
                    pc_load     = 1'b1;
                    pc_load_val = ADDR_W'(word);
                    state_d     = S_OP;
                    valid_d     = 1'b0;
                    int_d       = 1'b0;
                end
                S_OP: begin
                    if (bus.int_req) begin
                        // Instruction boundary: emit a bubble carrying the return PC.
                        ack_d   = 1'b1;
                        valid_d = 1'b1;
                        int_d   = 1'b1;
                        inst_d  = '0;
                        imm_d   = '0;
                        rpc_d   = pc;
                        rpcn_d  = pc;
                        state_d = S_IVEC;
                    end else if (is_two_word(word[15:11])) begin
                        held_inst_d = word;
                        held_pc_d   = pc;
                        pc_inc      = 1'b1;
                        valid_d     = 1'b0;
                        int_d       = 1'b0;
                        state_d     = S_IMM;
                    end else begin
                        valid_d = 1'b1;
                        int_d   = 1'b0;
                        inst_d  = word;
                        imm_d   = '0;
                        rpc_d   = pc;
                        rpcn_d  = pc_plus1;
                        pc_inc  = 1'b1;
                    end
                end
                S_IMM: begin
                    valid_d = 1'b1;
                    int_d   = 1'b0;
                    inst_d  = held_inst_q;
                    imm_d   = word;
                    rpc_d   = held_pc_q;
                    rpcn_d  = pc_plus1;
                    pc_inc  = 1'b1;
                    state_d = S_OP;
                end
                default: state_d = S_RVEC;
            endcase
        end
    end

    // Held opcode and IF/ID record registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_inst_q <= '0;
            held_pc_q   <= '0;
            valid_q     <= 1'b0;
            int_q       <= 1'b0;
            inst_q      <= '0;
            imm_q       <= '0;
            rpc_q       <= '0;
            rpcn_q      <= '0;
            ack_q       <= 1'b0;
        end else begin
            held_inst_q <= held_inst_d;
            held_pc_q   <= held_pc_d;
            valid_q     <= valid_d;
            int_q       <= int_d;
            inst_q      <= inst_d;
            imm_q       <= imm_d;
            rpc_q       <= rpc_d;
            rpcn_q      <= rpcn_d;
            ack_q       <= ack_d;
        end
    end

    assign bus.if_valid   = valid_q;
    assign bus.if_int     = int_q;
    assign bus.if_inst    = inst_q;
    assign bus.if_imm     = imm_q;
    assign bus.if_pc      = rpc_q;
    assign bus.if_pc_next = rpcn_q;
    assign bus.int_ack    = ack_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// against an instruction-level reference model.
module tb_fetch_unit;

    localparam logic [31:0] RVEC = 32'd0;
    localparam logic [31:0] IVEC = 32'd1;

    logic clk;
    logic rst_n;

    fetch_if #(.ADDR_W(32), .INST_W(16)) bus();

    fetch_unit #(.ADDR_W(32), .INST_W(16), .RST_VEC(RVEC), .INT_VEC(IVEC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0] mem [0:(1<<20)-1];
    assign bus.im_readData = mem[bus.im_address[19:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    // Reference model: PC, a pending vector fetch, a pending opcode awaiting its immediate.
    logic [31:0] m_pc, m_vec_addr, m_op_pc;
    logic [15:0] m_op;
    bit          m_boot, m_vec, m_have;
    bit          e_valid, e_int, e_ack;
    logic [15:0] e_inst, e_imm;
    logic [31:0] e_pc, e_pcn;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit two_word(input logic [15:0] w);
        return (w[15:11] == 5'b11010) || (w[15:11] == 5'b11011);
    endfunction

    task automatic model_reset();
        m_pc = 0; m_vec = 1; m_vec_addr = RVEC; m_boot = 1; m_have = 0;
        m_op = 0; m_op_pc = 0;
        e_valid = 0; e_int = 0; e_ack = 0; e_inst = 0; e_imm = 0; e_pc = 0; e_pcn = 0;
    endtask

    task automatic put(input logic [15:0] inst, input logic [15:0] imm,
                       input logic [31:0] pc, input logic [31:0] pcn);
        e_valid = 1; e_int = 0; e_ack = 0; e_inst = inst; e_imm = imm; e_pc = pc; e_pcn = pcn;
    endtask

    task automatic model_step(input bit st, input bit rd, input logic [31:0] rpc, input bit ir);
        logic [31:0] a;
        logic [15:0] w;
        a = m_vec ? m_vec_addr : m_pc;
        w = mem[a[19:0]];
        if (rd && !m_boot) begin
            m_pc = rpc; m_vec = 0; m_have = 0; e_valid = 0; e_int = 0; e_ack = 0;
        end else if (st) begin
            e_ack = 0;
        end else if (m_vec) begin
            m_pc = {16'h0, w}; m_vec = 0; m_boot = 0; e_valid = 0; e_int = 0; e_ack = 0;
        end else if (m_have) begin
            put(m_op, w, m_op_pc, m_pc + 32'd1);
            m_pc = m_pc + 32'd1; m_have = 0;
        end else if (ir) begin
            e_ack = 1; e_valid = 1; e_int = 1; e_inst = 0; e_pcn = m_pc;
            m_vec = 1; m_vec_addr = IVEC;
        end else if (two_word(w)) begin
            m_have = 1; m_op = w; m_op_pc = m_pc; m_pc = m_pc + 32'd1;
            e_valid = 0; e_int = 0; e_ack = 0;
        end else begin
            put(w, 16'h0, m_pc, m_pc + 32'd1);
            m_pc = m_pc + 32'd1;
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("im_address", bus.im_address, m_vec ? m_vec_addr : m_pc);
            chk("im_read", 32'(bus.im_read), 32'd1);
            chk("im_cs", 32'(bus.im_cs), 32'd1);
            chk("if_valid", 32'(bus.if_valid), 32'(e_valid));
            chk("if_int", 32'(bus.if_int), 32'(e_int));
            chk("int_ack", 32'(bus.int_ack), 32'(e_ack));
            if (e_valid) begin
                chk("if_inst", 32'(bus.if_inst), 32'(e_inst));
                chk("if_pc_next", bus.if_pc_next, e_pcn);
                if (!e_int) begin
                    chk("if_imm", 32'(bus.if_imm), 32'(e_imm));
                    chk("if_pc", bus.if_pc, e_pc);
                end
            end
        end
    end

    task automatic step(input bit st, input bit rd, input logic [31:0] rpc, input bit ir);
        @(negedge clk);
        #1;
        bus.stall = st; bus.redirect = rd; bus.redirect_pc = rpc; bus.int_req = ir;
        @(posedge clk);
        model_step(st, rd, rpc, ir);
        #2;
    endtask

    task automatic apply_reset();
        check_en = 0;
        rst_n = 0;
        bus.stall = 0; bus.redirect = 0; bus.redirect_pc = 0; bus.int_req = 0;
        model_reset();
        @(posedge clk);
        #2;
        chk("rst if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst if_inst", 32'(bus.if_inst), 32'd0);
        chk("rst if_imm", 32'(bus.if_imm), 32'd0);
        chk("rst if_pc", bus.if_pc, 32'd0);
        chk("rst if_pc_next", bus.if_pc_next, 32'd0);
        chk("rst if_int", 32'(bus.if_int), 32'd0);
        chk("rst int_ack", 32'(bus.int_ack), 32'd0);
        chk("rst im_read", 32'(bus.im_read), 32'd0);
        chk("rst im_cs", 32'(bus.im_cs), 32'd0);
        chk("rst im_address", bus.im_address, RVEC);
        rst_n = 1;
        check_en = 1;
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom);
        if ($urandom_range(0, 3) == 0) w[15:11] = ($urandom_range(0, 1) == 0) ? 5'b11010 : 5'b11011;
        return w;
    endfunction

    initial begin
        rst_n = 0;
        bus.stall = 0; bus.redirect = 0; bus.redirect_pc = 0; bus.int_req = 0;
        for (int i = 0; i < (1 << 20); i++) mem[i] = 16'h0000;

        // Reset vector boot.
        mem[0] = 16'd32; mem[32] = 16'h0000; mem[33] = 16'h0000;
        apply_reset();
        step(0, 0, 0, 0);
        chk("boot edge1 valid", 32'(bus.if_valid), 32'd0);
        chk("boot edge1 addr", bus.im_address, 32'd32);
        step(0, 0, 0, 0);
        chk("boot edge2 valid", 32'(bus.if_valid), 32'd1);
        chk("boot rec0 pc", bus.if_pc, 32'd32);
        step(0, 0, 0, 0);
        chk("boot rec1 pc", bus.if_pc, 32'd33);

        // Two-word instruction.
        mem[32] = 16'hD020; mem[33] = 16'h0005; mem[34] = 16'h0000;
        apply_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("ldm gap valid", 32'(bus.if_valid), 32'd0);
        step(0, 0, 0, 0);
        chk("ldm valid", 32'(bus.if_valid), 32'd1);
        chk("ldm inst", 32'(bus.if_inst), 32'h0000_D020);
        chk("ldm imm", 32'(bus.if_imm), 32'd5);
        chk("ldm pc", bus.if_pc, 32'd32);
        chk("ldm pc_next", bus.if_pc_next, 32'd34);
        step(0, 0, 0, 0);
        chk("after ldm pc", bus.if_pc, 32'd34);

        // Stall at PC 40.
        step(0, 1, 32'd40, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            chk("stall addr", bus.im_address, 32'd40);
            chk("stall valid", 32'(bus.if_valid), 32'd0);
        end
        step(0, 0, 0, 0);
        chk("post stall pc", bus.if_pc, 32'd40);
        chk("post stall valid", 32'(bus.if_valid), 32'd1);

        // Redirect with stall while the immediate is pending.
        mem[60] = 16'hD020; mem[61] = 16'h0005; mem[100] = 16'h0000;
        step(0, 1, 32'd60, 0);
        step(0, 0, 0, 0);
        chk("redir ldm gap", 32'(bus.if_valid), 32'd0);
        step(1, 1, 32'd100, 0);
        chk("redir squash valid", 32'(bus.if_valid), 32'd0);
        step(0, 0, 0, 0);
        chk("redir target valid", 32'(bus.if_valid), 32'd1);
        chk("redir target pc", bus.if_pc, 32'd100);

        // Interrupt entry at PC 50.
        mem[1] = 16'd200; mem[50] = 16'h0000; mem[200] = 16'h0000;
        step(0, 1, 32'd50, 0);
        step(0, 0, 0, 1);
        chk("irq ack", 32'(bus.int_ack), 32'd1);
        chk("irq bubble int", 32'(bus.if_int), 32'd1);
        chk("irq bubble valid", 32'(bus.if_valid), 32'd1);
        chk("irq bubble pc_next", bus.if_pc_next, 32'd50);
        step(0, 0, 0, 0);
        chk("irq ack drop", 32'(bus.int_ack), 32'd0);
        chk("irq vec valid", 32'(bus.if_valid), 32'd0);
        step(0, 0, 0, 0);
        chk("isr pc", bus.if_pc, 32'd200);
        chk("isr int", 32'(bus.if_int), 32'd0);

        // PC wrap, then asynchronous reset mid-cycle.
        mem[20'hFFFFF] = 16'h0000;
        step(0, 1, 32'hFFFF_FFFF, 0);
        step(0, 0, 0, 0);
        chk("wrap pc", bus.if_pc, 32'hFFFF_FFFF);
        chk("wrap pc_next", bus.if_pc_next, 32'd0);
        check_en = 0;
        rst_n = 0;
        #1;
        chk("async valid", 32'(bus.if_valid), 32'd0);
        chk("async cs", 32'(bus.im_cs), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 8192; i++) mem[i] = rand_word();
        mem[0] = 16'($urandom_range(16, 4000));
        mem[1] = 16'($urandom_range(16, 4000));
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 31) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 4000));
            step($urandom_range(0, 6) == 0, $urandom_range(0, 19) == 0, rpc,
                 $urandom_range(0, 15) == 0);
            if (i == 1500) begin
                check_en = 0;
                rst_n = 0;
                #1;
                chk("rand async valid", 32'(bus.if_valid), 32'd0);
                apply_reset();
            end
        end

        check_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
